// File: rtl/floor_request_scheduler_if.sv
// Bus between the elevator call-button front end, the SCAN scheduler and the motion controller.
// Carries served_count only when SERVICE_COUNT_EN is defined.
interface floor_request_scheduler_if #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
);
  logic [FLOORS-1:0]  req_pulse;
  logic [FLOOR_W-1:0] cur_floor;
  logic               arrived;
  logic [FLOORS-1:0]  pending;
  logic [FLOOR_W-1:0] target;
  logic               target_valid;
  logic [1:0]         dir;
`ifdef SERVICE_COUNT_EN
  logic [15:0]        served_count;
`endif

  modport master (
    output req_pulse, cur_floor, arrived,
`ifdef SERVICE_COUNT_EN
    input  served_count,
`endif
    input  pending, target, target_valid, dir
  );

  modport slave (
    input  req_pulse, cur_floor, arrived,
`ifdef SERVICE_COUNT_EN
    output served_count,
`endif
    output pending, target, target_valid, dir
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// Latches call-button pulses per floor and runs a SCAN sweep picking the next target floor.
// Optional SERVICE_COUNT_EN adds a saturating 16-bit count of served requests.
module floor_request_scheduler #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
) (
  input logic                      clk,
  input logic                      rst,
  floor_request_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} dir_e;

  localparam logic [FLOOR_W:0] NUM_FLOORS = FLOORS[FLOOR_W:0];

  logic [FLOORS-1:0]  pending_q, pending_d, clr;
  logic [FLOOR_W-1:0] target_q;
  logic               valid_q;
  dir_e               dir_q;

  logic               in_range, here, above_any, below_any;
  logic [FLOOR_W-1:0] lo_above, hi_below;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_range = ({1'b0, bus.cur_floor} < NUM_FLOORS);

  // Decode the registered pending set relative to the car's current floor.
  always_comb begin
    clr       = '0;
    here      = 1'b0;
    above_any = 1'b0;
    below_any = 1'b0;
    lo_above  = '0;
    hi_below  = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) > bus.cur_floor)) begin
        above_any = 1'b1;
        lo_above  = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) < bus.cur_floor)) begin
        below_any = 1'b1;
        hi_below  = FLOOR_W'(i);
      end
      if (FLOOR_W'(i) == bus.cur_floor) begin
        here   = pending_q[i];
        clr[i] = bus.arrived;
      end
    end
    pending_d = (pending_q | bus.req_pulse) & ~clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      target_q  <= '0;
      valid_q   <= 1'b0;
      dir_q     <= IDLE;
    end else begin
      pending_q <= pending_d;
      // Out-of-range floor freezes the sweep; otherwise continue ahead before reversing.
      if (in_range) begin
        case (dir_q)
          UP: begin
            if (above_any) begin
              target_q <= lo_above;
            end else if (here) begin
              target_q <= bus.cur_floor;
            end else if (below_any) begin
              dir_q    <= DOWN;
              target_q <= hi_below;
            end else begin
              dir_q   <= IDLE;
              valid_q <= 1'b0;
            end
          end
          DOWN: begin
            if (below_any) begin
              target_q <= hi_below;
            end else if (here) begin
              target_q <= bus.cur_floor;
            end else if (above_any) begin
              dir_q    <= UP;
              target_q <= lo_above;
            end else begin
              dir_q   <= IDLE;
              valid_q <= 1'b0;
            end
          end
          default: begin
            if (here) begin
              target_q <= bus.cur_floor;
              valid_q  <= 1'b1;
            end else if (above_any) begin
              dir_q    <= UP;
              target_q <= lo_above;
              valid_q  <= 1'b1;
            end else if (below_any) begin
              dir_q    <= DOWN;
              target_q <= hi_below;
              valid_q  <= 1'b1;
            end else begin
              valid_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.pending      = pending_q;
  assign bus.target       = target_q;
  assign bus.target_valid = valid_q;
  assign bus.dir          = dir_q;

`ifdef SERVICE_COUNT_EN
  logic [15:0] served_count_q, served_count_d;

  assign served_count_d = (bus.arrived && in_range && here) ? sat_inc(served_count_q)
                                                            : served_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) served_count_q <= '0;
    else      served_count_q <= served_count_d;
  end

  assign bus.served_count = served_count_q;
`endif

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: a 4-floor instance and a 3-floor instance
// for the out-of-range floor code. Define SERVICE_COUNT_EN to also exercise the counter.
module tb_floor_request_scheduler;

  logic clk;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  floor_request_scheduler_if #(.FLOORS(4), .FLOOR_W(2)) bus ();
  floor_request_scheduler_if #(.FLOORS(3), .FLOOR_W(2)) bus3 ();

  floor_request_scheduler #(.FLOORS(4), .FLOOR_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  floor_request_scheduler #(.FLOORS(3), .FLOOR_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    bus.req_pulse  = '0;
    bus.cur_floor  = '0;
    bus.arrived    = 1'b0;
    bus3.req_pulse = '0;
    bus3.cur_floor = '0;
    bus3.arrived   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_pulse = 4'b1111;
    bus.cur_floor = '0;
    bus.arrived   = 1'b0;
    tick();
    tick();
    compared++; if (bus.pending !== 4'b0000) begin mismatched++; $display("FAIL reset_pending got %b want 0000", bus.pending); end
    compared++; if (bus.dir !== 2'b00) begin mismatched++; $display("FAIL reset_dir got %b want 00", bus.dir); end
    compared++; if (bus.target_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", bus.target_valid); end
    compared++; if (bus.target !== 2'd0) begin mismatched++; $display("FAIL reset_target got %0d want 0", bus.target); end
    rst = 1'b1;
    tick();
    compared++; if (bus.pending !== 4'b1111) begin mismatched++; $display("FAIL reset_release_pending got %b want 1111", bus.pending); end
    compared++; if (bus.dir !== 2'b00) begin mismatched++; $display("FAIL reset_release_dir got %b want 00", bus.dir); end
    bus.req_pulse = '0;
  endtask

  task automatic test_single_request();
    do_reset();
    bus.cur_floor = 2'd0;
    bus.req_pulse = 4'b0100;
    tick();
    bus.req_pulse = '0;
    compared++; if (bus.pending !== 4'b0100) begin mismatched++; $display("FAIL single_pending got %b want 0100", bus.pending); end
    compared++; if (bus.target_valid !== 1'b0) begin mismatched++; $display("FAIL single_valid_early got %b want 0", bus.target_valid); end
    tick();
    compared++; if (bus.dir !== 2'b01) begin mismatched++; $display("FAIL single_dir_up got %b want 01", bus.dir); end
    compared++; if (bus.target !== 2'd2) begin mismatched++; $display("FAIL single_target got %0d want 2", bus.target); end
    compared++; if (bus.target_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid got %b want 1", bus.target_valid); end
    bus.cur_floor = 2'd2;
    bus.arrived   = 1'b1;
    tick();
    bus.arrived   = 1'b0;
    compared++; if (bus.pending !== 4'b0000) begin mismatched++; $display("FAIL single_cleared got %b want 0000", bus.pending); end
    tick();
    compared++; if (bus.dir !== 2'b00) begin mismatched++; $display("FAIL single_idle_dir got %b want 00", bus.dir); end
    compared++; if (bus.target_valid !== 1'b0) begin mismatched++; $display("FAIL single_idle_valid got %b want 0", bus.target_valid); end
    compared++; if (bus.target !== 2'd2) begin mismatched++; $display("FAIL single_target_hold got %0d want 2", bus.target); end
  endtask

  task automatic test_reversal();
    do_reset();
    bus.cur_floor = 2'd1;
    bus.req_pulse = 4'b1001;
    tick();
    bus.req_pulse = '0;
    tick();
    compared++; if (bus.dir !== 2'b01) begin mismatched++; $display("FAIL rev_dir_up got %b want 01", bus.dir); end
    compared++; if (bus.target !== 2'd3) begin mismatched++; $display("FAIL rev_target_up got %0d want 3", bus.target); end
    bus.cur_floor = 2'd3;
    bus.arrived   = 1'b1;
    tick();
    bus.arrived   = 1'b0;
    compared++; if (bus.pending !== 4'b0001) begin mismatched++; $display("FAIL rev_pending got %b want 0001", bus.pending); end
    compared++; if (bus.dir !== 2'b01) begin mismatched++; $display("FAIL rev_still_up got %b want 01", bus.dir); end
    tick();
    compared++; if (bus.dir !== 2'b10) begin mismatched++; $display("FAIL rev_dir_down got %b want 10", bus.dir); end
    compared++; if (bus.target !== 2'd0) begin mismatched++; $display("FAIL rev_target_down got %0d want 0", bus.target); end
    compared++; if (bus.target_valid !== 1'b1) begin mismatched++; $display("FAIL rev_valid got %b want 1", bus.target_valid); end
    bus.cur_floor = 2'd0;
    bus.arrived   = 1'b1;
    tick();
    bus.arrived   = 1'b0;
    compared++; if (bus.dir !== 2'b10) begin mismatched++; $display("FAIL rev_floor0_down got %b want 10", bus.dir); end
    tick();
    compared++; if (bus.dir !== 2'b00) begin mismatched++; $display("FAIL rev_end_idle got %b want 00", bus.dir); end
    compared++; if (bus.target_valid !== 1'b0) begin mismatched++; $display("FAIL rev_end_valid got %b want 0", bus.target_valid); end
  endtask

  task automatic test_clear_wins();
    do_reset();
    bus.cur_floor = 2'd1;
    bus.req_pulse = 4'b0010;
    bus.arrived   = 1'b1;
    tick();
    bus.req_pulse = '0;
    bus.arrived   = 1'b0;
    compared++; if (bus.pending !== 4'b0000) begin mismatched++; $display("FAIL clear_wins_pending got %b want 0000", bus.pending); end
`ifdef SERVICE_COUNT_EN
    compared++; if (bus.served_count !== 16'd0) begin mismatched++; $display("FAIL clear_wins_count got %0h want 0", bus.served_count); end
`endif
    tick();
    compared++; if (bus.target_valid !== 1'b0) begin mismatched++; $display("FAIL clear_wins_valid got %b want 0", bus.target_valid); end
    compared++; if (bus.dir !== 2'b00) begin mismatched++; $display("FAIL clear_wins_dir got %b want 00", bus.dir); end
  endtask

  task automatic test_full_sweep();
    do_reset();
    bus.cur_floor = 2'd1;
    bus.req_pulse = 4'b1111;
    tick();
    bus.req_pulse = '0;
    compared++; if (bus.pending !== 4'b1111) begin mismatched++; $display("FAIL sweep_pending got %b want 1111", bus.pending); end
    tick();
    compared++; if (bus.target !== 2'd1 || bus.dir !== 2'b00 || bus.target_valid !== 1'b1) begin mismatched++; $display("FAIL sweep_here got t=%0d d=%b v=%b want t=1 d=00 v=1", bus.target, bus.dir, bus.target_valid); end
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    compared++; if (bus.pending !== 4'b1101) begin mismatched++; $display("FAIL sweep_clr1 got %b want 1101", bus.pending); end
    tick();
    compared++; if (bus.target !== 2'd2 || bus.dir !== 2'b01) begin mismatched++; $display("FAIL sweep_up2 got t=%0d d=%b want t=2 d=01", bus.target, bus.dir); end
    bus.cur_floor = 2'd2;
    bus.arrived   = 1'b1;
    tick();
    bus.arrived   = 1'b0;
    compared++; if (bus.target !== 2'd3 || bus.dir !== 2'b01) begin mismatched++; $display("FAIL sweep_up3 got t=%0d d=%b want t=3 d=01", bus.target, bus.dir); end
    bus.cur_floor = 2'd3;
    bus.arrived   = 1'b1;
    tick();
    bus.arrived   = 1'b0;
    compared++; if (bus.pending !== 4'b0001) begin mismatched++; $display("FAIL sweep_clr3 got %b want 0001", bus.pending); end
    tick();
    compared++; if (bus.target !== 2'd0 || bus.dir !== 2'b10) begin mismatched++; $display("FAIL sweep_down0 got t=%0d d=%b want t=0 d=10", bus.target, bus.dir); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus3.cur_floor = 2'd0;
    bus3.req_pulse = 3'b010;
    tick();
    bus3.req_pulse = '0;
    tick();
    compared++; if (bus3.target !== 2'd1 || bus3.dir !== 2'b01 || bus3.target_valid !== 1'b1) begin mismatched++; $display("FAIL oor_setup got t=%0d d=%b v=%b want t=1 d=01 v=1", bus3.target, bus3.dir, bus3.target_valid); end
    bus3.cur_floor = 2'd3;
    bus3.arrived   = 1'b1;
    tick();
    bus3.arrived   = 1'b0;
    compared++; if (bus3.pending !== 3'b010) begin mismatched++; $display("FAIL oor_pending got %b want 010", bus3.pending); end
    tick();
    compared++; if (bus3.dir !== 2'b01) begin mismatched++; $display("FAIL oor_dir got %b want 01", bus3.dir); end
    compared++; if (bus3.target !== 2'd1) begin mismatched++; $display("FAIL oor_target got %0d want 1", bus3.target); end
    compared++; if (bus3.target_valid !== 1'b1) begin mismatched++; $display("FAIL oor_valid got %b want 1", bus3.target_valid); end
  endtask

`ifdef SERVICE_COUNT_EN
  task automatic test_service_count();
    do_reset();
    bus.cur_floor = 2'd0;
    bus.req_pulse = 4'b0001;
    tick();
    // One service per cycle: arrive at the floor requested last cycle, request the other.
    for (int k = 1; k <= 65537; k++) begin
      bus.cur_floor = FLOOR_SEL(k - 1);
      bus.req_pulse = (k[0]) ? 4'b0010 : 4'b0001;
      bus.arrived   = 1'b1;
      tick();
      if (k == 65534) begin
        compared++; if (bus.served_count !== 16'hFFFE) begin mismatched++; $display("FAIL count_fffe got %0h want fffe", bus.served_count); end
      end
      if (k == 65535) begin
        compared++; if (bus.served_count !== 16'hFFFF) begin mismatched++; $display("FAIL count_ffff got %0h want ffff", bus.served_count); end
      end
      if (k == 65537) begin
        compared++; if (bus.served_count !== 16'hFFFF) begin mismatched++; $display("FAIL count_saturate got %0h want ffff", bus.served_count); end
      end
    end
    bus.arrived   = 1'b0;
    bus.req_pulse = '0;
  endtask

  function automatic logic [1:0] FLOOR_SEL(input int k);
    return (k % 2 == 0) ? 2'd0 : 2'd1;
  endfunction
`endif

  initial begin
    rst            = 1'b0;
    bus.req_pulse  = '0;
    bus.cur_floor  = '0;
    bus.arrived    = 1'b0;
    bus3.req_pulse = '0;
    bus3.cur_floor = '0;
    bus3.arrived   = 1'b0;
    test_reset();
    test_single_request();
    test_reversal();
    test_clear_wins();
    test_full_sweep();
    test_out_of_range();
`ifdef SERVICE_COUNT_EN
    test_service_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
- Sits directly downstream of the per-button debouncers in the elevator controller.
- Latches the single-cycle rising-edge pulses from the call buttons into a pending-request register, one bit per floor.
- Runs a SCAN (up/down sweep) state machine that selects the next target floor and travel direction for the car motion controller.
- Clears a floor's request when the motion controller reports arrival at that floor.

Parameters:
- FLOORS, 4, number of served floors; must be ≥ 2.
- FLOOR_W, 2, width of floor index; FLOORS ≤ 2**FLOOR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_pulse  input  FLOORS  one-cycle call pulses from the debouncers; bit i = floor i.
- cur_floor  input  FLOOR_W  current car floor from the motion controller.
- arrived  input  1  one-cycle pulse: car has stopped and served cur_floor.
- pending  output  FLOORS  registered outstanding requests.
- target  output  FLOOR_W  registered next floor to serve.
- target_valid  output  1  target is meaningful.
- dir  output  2  registered direction state: 00 IDLE, 01 UP, 10 DOWN; 11 never driven.

Behaviour:
- Reset, when rst is low (asynchronous):
  - pending = 0, target = 0, target_valid = 0, dir = IDLE.
  - All state is discarded mid-operation.
  - Synchronous resume on the first clk edge after rst goes high.
- Request latch, every cycle: pending <= (pending | req_pulse) & ~clr.
  - clr is one-hot at cur_floor when arrived = 1; otherwise clr = 0.
  - A req_pulse at cur_floor in the same cycle as arrived is discarded (clear wins).
  - Repeated pulses for an already-pending floor have no effect.
- Out-of-range floor: cur_floor ≥ FLOORS.
  - arrived is ignored.
  - The FSM holds dir, target and target_valid unchanged.
- Scheduler FSM: evaluated on registered pending and current cur_floor; outputs are registered.
  - Latency: req_pulse at edge n → pending at n+1 → target/dir at n+2.
  - "above" = pending bits with index > cur_floor; "below" = index < cur_floor; "here" = pending[cur_floor].
- IDLE state:
  - here → stay IDLE, target = cur_floor, valid = 1.
  - else above → UP, target = lowest above, valid = 1.
  - else below → DOWN, target = highest below, valid = 1.
  - else stay IDLE, valid = 0, target holds its last value.
  - Above takes priority over below when both exist.
- UP state:
  - above → stay UP, target = lowest above.
  - else here → stay UP, target = cur_floor.
  - else below → DOWN, target = highest below.
  - else → IDLE, valid = 0.
- DOWN state: mirror of UP.
  - below → lowest-index-closest, i.e. highest below.
  - else here → cur_floor.
  - else above → UP, target = lowest above.
  - else → IDLE.
- Direction reversal only occurs when no request remains ahead of the car in the current direction. There is no mid-sweep reversal.
- Boundaries:
  - At top floor (cur_floor = FLOORS-1) in UP, above is empty by construction.
  - At floor 0 in DOWN, below is empty by construction.
  - All FLOORS bits set simultaneously: served strictly in sweep order.

Optional Feature:
- Macro SERVICE_COUNT_EN.
- When defined, adds output port served_count [15:0]:
  - Reset to 0.
  - Increments by 1 on each cycle where arrived = 1, cur_floor is in range, and pending[cur_floor] = 1.
  - Saturates at 16'hFFFF; no wrap.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with req_pulse = 4'b1111 held → pending = 0, dir = 00, target_valid = 0. Release rst; one cycle later pending = 1111.
- cur_floor = 0, IDLE, single req_pulse[2] pulse → pending = 0100 at next edge; dir = UP, target = 2, valid = 1 one edge later. arrived with cur_floor = 2 → pending = 0000; then dir = IDLE, valid = 0.
- cur_floor = 1, dir = UP, pending = 1001 → target = 3. Pulse arrived at floor 3 → dir = DOWN, target = 0 (reversal only after sweep exhausted).
- req_pulse[1] and arrived with cur_floor = 1 in the same cycle → pending[1] stays 0 (clear wins). With SERVICE_COUNT_EN, served_count unchanged if pending[1] was 0 before.
- cur_floor = 2'b11 with FLOORS = 3, arrived pulsed → pending, target, dir unchanged.
- SERVICE_COUNT_EN: force count to FFFE via 2 services from a preload sequence → increments to FFFF, then stays FFFF.
